// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : led_pkg
//  Description: Shared definitions for the multi-channel LED driver:
//               channel mode encodings and the channel-select width helper.
//  Revision   : 1.0  initial release
// ============================================================================
package led_pkg;

   // Channel operating modes, as written on the config port.
   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_ON    = 2'd1;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_PWM   = 2'd3;

   // Channel-select width; a single channel still gets a one-bit select.
   function automatic int ch_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
// ============================================================================
//  Module     : led_channel
//  Description: One LED channel. Holds the channel's mode/half-period/duty
//               configuration, the blink counter and phase bit, and the
//               registered (optionally inverted) LED output.
//  Revision   : 1.0  initial release
// ============================================================================
module led_channel
   import led_pkg::*;
#(
   parameter int   CNT_W    = 16,
   parameter int   PWM_W    = 8,
   parameter int   DEF_HALF = 250,
   parameter logic INV      = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             we_i,
   input  logic             sync_i,
   input  logic             tick_i,
   input  logic [1:0]       mode_i,
   input  logic [CNT_W-1:0] half_i,
   input  logic [PWM_W-1:0] duty_i,
   input  logic [PWM_W-1:0] pwm_cnt_i,
   output logic             led_o
);

   // Reset duty is exactly half scale.
   localparam logic [PWM_W-1:0] c_def_duty = PWM_W'(1) << (PWM_W - 1);
   localparam logic [CNT_W-1:0] c_def_half = CNT_W'(DEF_HALF);

   logic [1:0]       mode_q,  mode_d;
   logic [CNT_W-1:0] half_q,  half_d;
   logic [PWM_W-1:0] duty_q,  duty_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             state_q, state_d;
   logic             led_q,   led_d;

   logic [CNT_W-1:0] eff_half;
   logic             raw_lvl;

   // A zero half-period would never expire, so it is treated as one tick.
   assign eff_half = (half_q == '0) ? CNT_W'(1) : half_q;

   // Raw level from the current mode; PWM is an unsigned compare against the shared counter.
   always_comb begin
      raw_lvl = 1'b0;
      case (mode_q)
         MODE_OFF:   raw_lvl = 1'b0;
         MODE_ON:    raw_lvl = 1'b1;
         MODE_BLINK: raw_lvl = state_q;
         MODE_PWM:   raw_lvl = (pwm_cnt_i < duty_q);
         default:    raw_lvl = 1'b0;
      endcase
   end

   // Next-state: a write or SYNC clears the blink timer and beats any coincident tick.
   always_comb begin
      mode_d  = mode_q;
      half_d  = half_q;
      duty_d  = duty_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      led_d   = raw_lvl ^ INV;
      if (we_i) begin
         mode_d  = mode_i;
         half_d  = half_i;
         duty_d  = duty_i;
         cnt_d   = '0;
         state_d = 1'b0;
      end else if (sync_i) begin
         cnt_d   = '0;
         state_d = 1'b0;
      end else if (tick_i) begin
         // ">=" so that lowering the half-period below the count toggles on the next tick.
         if (cnt_q >= eff_half - CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ~state_q;
         end else begin
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end
   end

   // Channel registers; reset leaves the channel blinking at the default rate.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q  <= MODE_BLINK;
         half_q  <= c_def_half;
         duty_q  <= c_def_duty;
         cnt_q   <= '0;
         state_q <= 1'b0;
         led_q   <= INV;
      end else begin
         mode_q  <= mode_d;
         half_q  <= half_d;
         duty_q  <= duty_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         led_q   <= led_d;
      end
   end

   assign led_o = led_q;

endmodule
`default_nettype wire

// File: rtl/multi_led_blinker.sv
`default_nettype none
// ============================================================================
//  Module     : multi_led_blinker
//  Description: N-channel LED driver. Shared prescaler tick and free-running
//               PWM counter, config-write decode and SYNC fan-out to one
//               led_channel per output.
//  Revision   : 1.0  initial release
// ============================================================================
module multi_led_blinker
   import led_pkg::*;
#(
   parameter int          NUM_CH    = 2,
   parameter int          CLK_HZ    = 12_000_000,
   parameter int          TICK_HZ   = 1000,
   parameter int          CNT_W     = 16,
   parameter int          DEF_HALF  = 250,
   parameter int          PWM_W     = 8,
   parameter logic [15:0] PHASE_INV = 16'b10,
   localparam int         CH_W      = ch_w(NUM_CH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cfg_we_i,
   input  logic [CH_W-1:0]   cfg_ch_i,
   input  logic [1:0]        cfg_mode_i,
   input  logic [CNT_W-1:0]  cfg_half_i,
   input  logic [PWM_W-1:0]  cfg_duty_i,
   input  logic              sync_i,
   output logic              tick_o,
   output logic [NUM_CH-1:0] led_o
);

   localparam int c_tick_div = CLK_HZ / TICK_HZ;
   localparam int c_pre_w    = $clog2(c_tick_div);
   localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(c_tick_div - 1);

   logic [1:0]         rst_sync_q;
   logic               rst_n_int;
   logic [c_pre_w-1:0] presc_q, presc_d;
   logic               tick_q,  tick_d;
   logic [PWM_W-1:0]   pwm_q,   pwm_d;

   // Reset asserts immediately but is released only on a clock edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_int = rst_sync_q[1];

   // Prescaler wraps at TICK_DIV-1; the tick pulse follows the terminal count by one cycle.
   always_comb begin
      presc_d = (presc_q == c_pre_last) ? '0 : presc_q + c_pre_w'(1);
      tick_d  = (presc_q == c_pre_last);
      pwm_d   = pwm_q + PWM_W'(1);
      if (sync_i) begin
         presc_d = '0;
         tick_d  = 1'b0;
         pwm_d   = '0;
      end
   end

   // Shared timebase registers.
   always_ff @(posedge clk_i or negedge rst_n_int) begin
      if (!rst_n_int) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
         pwm_q   <= '0;
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
         pwm_q   <= pwm_d;
      end
   end

   assign tick_o = tick_q;

   // One channel per LED; a write addressed past the last channel matches none of them.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic ch_we;
      assign ch_we = cfg_we_i && (cfg_ch_i == CH_W'(i));

      led_channel #(
         .CNT_W    (CNT_W),
         .PWM_W    (PWM_W),
         .DEF_HALF (DEF_HALF),
         .INV      (PHASE_INV[i])
      ) u_ch (
         .clk_i     (clk_i),
         .rst_ni    (rst_n_int),
         .we_i      (ch_we),
         .sync_i    (sync_i),
         .tick_i    (tick_q),
         .mode_i    (cfg_mode_i),
         .half_i    (cfg_half_i),
         .duty_i    (cfg_duty_i),
         .pwm_cnt_i (pwm_q),
         .led_o     (led_o[i])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_multi_led_blinker.sv
`default_nettype none
// ============================================================================
//  Module     : tb_multi_led_blinker
//  Description: Self-checking bench for multi_led_blinker. Three channels are
//               used so that a two-bit channel select can address a channel
//               that does not exist.
//  Revision   : 1.0  initial release
// ============================================================================
module tb_multi_led_blinker;

   localparam int         NCH   = 3;
   localparam int         DIV   = 12;
   localparam int         PWM_N = 256;
   localparam int         DHALF = 3;
   localparam logic [2:0] INV   = 3'b010;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        cfg_we_i;
   logic [1:0]  cfg_ch_i;
   logic [1:0]  cfg_mode_i;
   logic [15:0] cfg_half_i;
   logic [7:0]  cfg_duty_i;
   logic        sync_i;
   logic        tick_o;
   logic [2:0]  led_o;

   int n_checks = 0;
   int n_errs   = 0;

   // Reference model: time since alignment, plus per-channel config and blink phase.
   int         cyc;
   int         m_mode  [NCH];
   int         m_half  [NCH];
   int         m_duty  [NCH];
   int         m_cnt   [NCH];
   bit         m_state [NCH];
   logic [2:0] m_led;

   multi_led_blinker #(
      .NUM_CH    (NCH),
      .CLK_HZ    (12_000),
      .TICK_HZ   (1000),
      .CNT_W     (16),
      .DEF_HALF  (DHALF),
      .PWM_W     (8),
      .PHASE_INV (16'b010)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .cfg_we_i   (cfg_we_i),
      .cfg_ch_i   (cfg_ch_i),
      .cfg_mode_i (cfg_mode_i),
      .cfg_half_i (cfg_half_i),
      .cfg_duty_i (cfg_duty_i),
      .sync_i     (sync_i),
      .tick_o     (tick_o),
      .led_o      (led_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // A tick is seen every DIV cycles after alignment, never in the cycle right after it.
   function automatic bit exp_tick();
      return (cyc > 0) && (cyc % DIV == 0);
   endfunction

   function automatic bit raw_level(input int i);
      case (m_mode[i])
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return m_state[i];
         default: return (cyc % PWM_N) < m_duty[i];
      endcase
   endfunction

   task automatic model_defaults();
      cyc = 0;
      for (int i = 0; i < NCH; i++) begin
         m_mode[i]  = 2;
         m_half[i]  = DHALF;
         m_duty[i]  = PWM_N / 2;
         m_cnt[i]   = 0;
         m_state[i] = 1'b0;
      end
      m_led = INV;
   endtask

   // Advance the model across one clock edge using the inputs currently applied.
   task automatic model_edge();
      logic [2:0] nled;
      bit tk;
      int eff;
      tk = exp_tick();
      for (int i = 0; i < NCH; i++) nled[i] = raw_level(i) ^ INV[i];
      for (int i = 0; i < NCH; i++) begin
         if (cfg_we_i && (int'(cfg_ch_i) == i)) begin
            m_mode[i]  = int'(cfg_mode_i);
            m_half[i]  = int'(cfg_half_i);
            m_duty[i]  = int'(cfg_duty_i);
            m_cnt[i]   = 0;
            m_state[i] = 1'b0;
         end else if (sync_i) begin
            m_cnt[i]   = 0;
            m_state[i] = 1'b0;
         end else if (tk) begin
            eff = (m_half[i] == 0) ? 1 : m_half[i];
            if (m_cnt[i] >= eff - 1) begin
               m_cnt[i]   = 0;
               m_state[i] = !m_state[i];
            end else begin
               m_cnt[i]++;
            end
         end
      end
      m_led = nled;
      cyc   = sync_i ? 0 : cyc + 1;
   endtask

   // One clock with the given inputs; outputs are compared at the following falling edge.
   task automatic step(input bit we, input int ch, input int mode, input int half,
                       input int duty, input bit sy);
      cfg_we_i   = we;
      cfg_ch_i   = 2'(ch);
      cfg_mode_i = 2'(mode);
      cfg_half_i = 16'(half);
      cfg_duty_i = 8'(duty);
      sync_i     = sy;
      @(posedge clk_i);
      model_edge();
      @(negedge clk_i);
      check("led", led_o, m_led);
      check("tick", tick_o, exp_tick());
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 0, 0, 0, 0, 1'b0);
   endtask

   task automatic wr(input int ch, input int mode, input int half, input int duty);
      step(1'b1, ch, mode, half, duty, 1'b0);
   endtask

   // Release reset and hold SYNC across the release so the timebase starts at a known point.
   task automatic align();
      cfg_we_i = 1'b0;
      sync_i   = 1'b1;
      rst_ni   = 1'b1;
      repeat (4) @(posedge clk_i);
      @(negedge clk_i);
      sync_i = 1'b0;
      model_defaults();
      check("align_led", led_o, m_led);
      check("align_tick", tick_o, 1'b0);
   endtask

   task automatic pwm_window(input string tag, input int duty);
      int hi;
      hi = 0;
      wr(0, 3, 0, duty);
      for (int k = 0; k < PWM_N; k++) begin
         idle(1);
         hi += int'(led_o[0]);
      end
      check(tag, hi, duty);
   endtask

   initial begin
      int tcount;
      int guard;
      rst_ni     = 1'b0;
      cfg_we_i   = 1'b0;
      cfg_ch_i   = '0;
      cfg_mode_i = '0;
      cfg_half_i = '0;
      cfg_duty_i = '0;
      sync_i     = 1'b0;
      repeat (3) @(negedge clk_i);
      check("rst_led", led_o, 3'b010);
      check("rst_tick", tick_o, 1'b0);
      align();

      // Default blinking: ticks every DIV cycles, channels blink at the default half-period.
      tcount = 0;
      for (int k = 0; k < 120; k++) begin
         idle(1);
         tcount += int'(tick_o);
      end
      check("tick_count", tcount, 10);

      // PWM duty fractions over one full PWM period.
      pwm_window("pwm_duty64", 64);
      pwm_window("pwm_duty0", 0);
      pwm_window("pwm_duty255", 255);

      // Static levels on the inverted channel, one cycle after the write.
      wr(1, 1, 0, 0);
      idle(1);
      check("ch1_on", led_o[1], 1'b0);
      wr(1, 0, 0, 0);
      idle(1);
      check("ch1_off", led_o[1], 1'b1);

      // Zero half-period, then a half-period change mid-count.
      wr(0, 2, 0, 0);
      idle(60);
      wr(0, 2, 6, 0);
      guard = 0;
      while (m_cnt[0] != 4 && guard < 200) begin
         idle(1);
         guard++;
      end
      check("cnt4_reached", guard < 200, 1'b1);
      wr(0, 2, 5, 0);
      idle(80);

      // Channels out of phase, then SYNC realigns them and restarts the tick.
      wr(0, 2, 3, 0);
      idle(7);
      wr(1, 2, 3, 0);
      idle(20);
      step(1'b0, 0, 0, 0, 0, 1'b1);
      guard = 0;
      while (tick_o !== 1'b1 && guard < 40) begin
         idle(1);
         guard++;
      end
      check("sync_tick_gap", guard, 12);
      idle(60);

      // Out-of-range channel is ignored; SYNC and a write on the same edge.
      wr(3, 1, 0, 0);
      idle(5);
      step(1'b1, 2, 3, 1, 100, 1'b1);
      idle(30);

      // Reset in the middle of PWM operation.
      wr(0, 3, 0, 100);
      idle(37);
      #2 rst_ni = 1'b0;
      #1;
      check("async_rst_led", led_o, 3'b010);
      check("async_rst_tick", tick_o, 1'b0);
      repeat (2) @(negedge clk_i);
      check("held_rst_led", led_o, 3'b010);
      align();
      idle(100);

      // Randomised writes and SYNC pulses against the model.
      for (int k = 0; k < 3000; k++) begin
         step(($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 255)), ($urandom_range(0, 63) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
